// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the unified-memory port arbiter of the multicycle
// MIPS core: arbiter FSM state encodings and master/owner codes.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    // Access sequencing: sample requests, strobe memory, wait out the memory
    // latency, then pulse ready back to the master that won.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arbState_t;

    // Owner codes as seen on the owner output and the grant of arb_pick.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the CPU and DMA request lines.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate between masters on
// simultaneous requests (winner is the master not served last). Without it,
// the CPU always wins a tie and the DMA port can be starved, which is fine for
// a boot loader that only runs while the CPU is quiet.
//
// Ports
//   cpu_req_i  in   1  CPU request
//   dma_req_i  in   1  DMA request
//   last_i     in   1  master served by the previous access (OWN_CPU/OWN_DMA)
//   grant_o    out  1  selected master (OWN_CPU/OWN_DMA), meaningful with valid_o
//   valid_o    out  1  at least one request present
// ---------------------------------------------------------------------------
module arb_pick
    import mips_mem_pkg::*;
(
    input  logic cpu_req_i,
    input  logic dma_req_i,
    input  logic last_i,
    output logic grant_o,
    output logic valid_o
);

    assign valid_o = cpu_req_i | dma_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    // Tie goes to whichever master did not get the previous access; a lone
    // requester always wins.
    always_comb begin
        grant_o = OWN_CPU;
        if (cpu_req_i && dma_req_i) begin
            grant_o = (last_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (dma_req_i) begin
            grant_o = OWN_DMA;
        end
    end
`else
    // Fixed priority: history is irrelevant here.
    logic unusedLast;
    assign unusedLast = last_i;

    always_comb begin
        grant_o = OWN_CPU;
        if (!cpu_req_i && dma_req_i) begin
            grant_o = OWN_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified instruction/data memory of the multicycle MIPS
// core between the CPU (controller-driven fetch/load/store) and a DMA/loader
// port. Accesses are serialised: one access every MEM_LAT+3 cycles, ready
// returned MEM_LAT+2 cycles after the request is accepted in IDLE.
//
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick) selects round-robin
// tie-breaking; default is fixed CPU priority.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles from the mem_en cycle to mem_rdata valid (>= 1)
//
// Ports
//   clk                 in   1   clock, rising edge
//   reset               in   1   asynchronous reset, active low
//   cpu_req/dma_req     in   1   access request, held stable until ready
//   cpu_we/dma_we       in   1   1 = write, 0 = read
//   cpu_addr/dma_addr   in   AW  byte address
//   cpu_wdata/dma_wdata in   DW  write data
//   cpu_rdata/dma_rdata out  DW  read data, held until that master's next read
//   cpu_ready/dma_ready out  1   one-cycle completion pulse
//   mem_en              out  1   memory strobe, one cycle per access
//   mem_we              out  1   memory write enable, only with mem_en
//   mem_addr            out  AW  memory address, 0 while mem_en = 0
//   mem_wdata           out  DW  memory write data, 0 while mem_en = 0
//   mem_rdata           in   DW  memory read data
//   owner               out  1   current/last granted master (0 CPU, 1 DMA)
//   busy                out  1   FSM not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    // Counter is loaded with MEM_LAT-1 and only counts down to zero.
    localparam int            CW       = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    arbState_t     state_q, state_d;
    logic          owner_q, owner_d;
    logic          lastServed_q, lastServed_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpuRdata_q, cpuRdata_d;
    logic [DW-1:0] dmaRdata_q, dmaRdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          grant;
    logic          reqValid;

    arb_pick u_pick (
        .cpu_req_i (cpu_req),
        .dma_req_i (dma_req),
        .last_i    (lastServed_q),
        .grant_o   (grant),
        .valid_o   (reqValid)
    );

    // Next-state logic. Request lines are only looked at in IDLE, so a master
    // changing its request mid-access has no effect until the FSM returns.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lastServed_d = lastServed_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpuRdata_d   = cpuRdata_q;
        dmaRdata_d   = dmaRdata_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    owner_d      = grant;
                    lastServed_d = grant;
                    we_d         = (grant == OWN_DMA) ? dma_we    : cpu_we;
                    addr_d       = (grant == OWN_DMA) ? dma_addr  : cpu_addr;
                    wdata_d      = (grant == OWN_DMA) ? dma_wdata : cpu_wdata;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Writes leave both read-data registers untouched.
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) begin
                            dmaRdata_d = mem_rdata;
                        end else begin
                            cpuRdata_d = mem_rdata;
                        end
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any access in flight without a ready
    // pulse; a write already strobed into memory stays written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            lastServed_q <= OWN_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpuRdata_q   <= '0;
            dmaRdata_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lastServed_q <= lastServed_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpuRdata_q   <= cpuRdata_d;
            dmaRdata_q   <= dmaRdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs decode straight from the state register so that reset clears
    // them in the same cycle it is asserted.
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign cpu_ready = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign dma_ready = (state_q == S_DONE) && (owner_q == OWN_DMA);
    assign cpu_rdata = cpuRdata_q;
    assign dma_rdata = dmaRdata_q;

    assign owner = owner_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance driven from a
// table of single accesses plus hand-written multi-cycle sequences, and a
// MEM_LAT=3 instance fed by a small counting memory model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // MEM_LAT = 1 instance
    logic        cpuReq = 1'b0, cpuWe = 1'b0;
    logic [31:0] cpuAddr = '0, cpuWdata = '0, cpuRdata;
    logic        cpuReady;
    logic        dmaReq = 1'b0, dmaWe = 1'b0;
    logic [31:0] dmaAddr = '0, dmaWdata = '0, dmaRdata;
    logic        dmaReady;
    logic        memEn, memWe;
    logic [31:0] memAddr, memWdata;
    logic [31:0] memRdata = '0;
    logic        owner, busy;

    // MEM_LAT = 3 instance
    logic        cpuReq2 = 1'b0;
    logic [31:0] cpuAddr2 = '0;
    logic [31:0] cpuRdata2, dmaRdata2, memAddr2, memWdata2, memRdata2;
    logic        cpuReady2, dmaReady2, memEn2, memWe2, owner2, busy2;
    logic [3:0]  lat3Count = '0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_rdata(cpuRdata), .cpu_ready(cpuReady),
        .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
        .dma_rdata(dmaRdata), .dma_ready(dmaReady),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dutLat3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpuReq2), .cpu_we(1'b0), .cpu_addr(cpuAddr2), .cpu_wdata(32'd0),
        .cpu_rdata(cpuRdata2), .cpu_ready(cpuReady2),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
        .dma_rdata(dmaRdata2), .dma_ready(dmaReady2),
        .mem_en(memEn2), .mem_we(memWe2), .mem_addr(memAddr2), .mem_wdata(memWdata2),
        .mem_rdata(memRdata2), .owner(owner2), .busy(busy2)
    );

    // Memory model for the slow instance: the read data carries the number of
    // cycles elapsed since the strobe, so the captured word shows which cycle
    // was sampled.
    always @(posedge clk) begin
        if (memEn2) begin
            lat3Count <= 4'd1;
        end else if (lat3Count != 4'd0 && lat3Count != 4'd15) begin
            lat3Count <= lat3Count + 4'd1;
        end
    end
    assign memRdata2 = 32'hA000_0000 | {28'd0, lat3Count};

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Results of the last applyStimulus call
    int          resReadyCycle;
    int          resEnCount;
    logic [31:0] resEnAddr, resEnWdata;
    logic        resEnWe, resOtherReady, resStray;

    // One access from one master with the other idle; counts cycles from the
    // request (raised at a negedge) to the ready pulse and records what the
    // memory side showed on the way.
    task automatic applyStimulus(input logic isDma, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] memData);
        resReadyCycle = -1;
        resEnCount    = 0;
        resEnAddr     = '0;
        resEnWdata    = '0;
        resEnWe       = 1'b0;
        resOtherReady = 1'b0;
        resStray      = 1'b0;
        memRdata      = memData;
        if (isDma) begin
            dmaWe = we; dmaAddr = addr; dmaWdata = wdata; dmaReq = 1'b1;
        end else begin
            cpuWe = we; cpuAddr = addr; cpuWdata = wdata; cpuReq = 1'b1;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (memEn) begin
                resEnCount++;
                resEnAddr  = memAddr;
                resEnWe    = memWe;
                resEnWdata = memWdata;
            end else if (memWe || memAddr != 32'd0) begin
                resStray = 1'b1;
            end
            if (isDma ? cpuReady : dmaReady) resOtherReady = 1'b1;
            if (isDma ? dmaReady : cpuReady) begin
                resReadyCycle = c;
                break;
            end
        end
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        @(negedge clk);
    endtask

    // Results of the last runDual call: who code 1 = CPU, 2 = DMA, 3 = both
    int   dualWho1, dualWho2, dualCycle1, dualCycle2;
    logic dualOwner1, dualOwner2;

    task automatic runDual(input logic [31:0] memData);
        int nReady;
        nReady     = 0;
        dualWho1   = 0; dualWho2 = 0; dualCycle1 = -1; dualCycle2 = -1;
        dualOwner1 = 1'b0; dualOwner2 = 1'b0;
        memRdata   = memData;
        cpuWe = 1'b0; cpuAddr = 32'h300;
        dmaWe = 1'b0; dmaAddr = 32'h400;
        cpuReq = 1'b1; dmaReq = 1'b1;
        for (int c = 1; c <= 20 && nReady < 2; c++) begin
            @(negedge clk);
            if (cpuReady || dmaReady) begin
                if (nReady == 0) begin
                    dualWho1 = {30'd0, dmaReady, cpuReady}; dualCycle1 = c; dualOwner1 = owner;
                end else begin
                    dualWho2 = {30'd0, dmaReady, cpuReady}; dualCycle2 = c; dualOwner2 = owner;
                end
                nReady++;
                if (cpuReady) cpuReq = 1'b0;
                if (dmaReady) dmaReq = 1'b0;
            end
        end
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        isDma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memData;
        logic [31:0] expCpuRdata;
        logic [31:0] expDmaRdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          readyCycle;
        int          enCount;
        logic [31:0] cpuBefore;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h55AA_55AA, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001};

        // Reset state
        #1;
        checkOutput("reset mem_en",    32'(memEn),    32'd0);
        checkOutput("reset mem_we",    32'(memWe),    32'd0);
        checkOutput("reset mem_addr",  memAddr,       32'd0);
        checkOutput("reset mem_wdata", memWdata,      32'd0);
        checkOutput("reset cpu_ready", 32'(cpuReady), 32'd0);
        checkOutput("reset dma_ready", 32'(dmaReady), 32'd0);
        checkOutput("reset cpu_rdata", cpuRdata,      32'd0);
        checkOutput("reset dma_rdata", dmaRdata,      32'd0);
        checkOutput("reset owner",     32'(owner),    32'd0);
        checkOutput("reset busy",      32'(busy),     32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle busy", 32'(busy), 32'd0);

        // Table of single accesses
        $display("[TB] single-access vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].isDma, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].memData);
            checkOutput($sformatf("v%0d ready latency", i), 32'(resReadyCycle), 32'd3);
            checkOutput($sformatf("v%0d mem_en count", i),  32'(resEnCount),    32'd1);
            checkOutput($sformatf("v%0d mem_addr", i),      resEnAddr,          vecs[i].addr);
            checkOutput($sformatf("v%0d mem_we", i),        32'(resEnWe),       32'(vecs[i].we));
            if (vecs[i].we) begin
                checkOutput($sformatf("v%0d mem_wdata", i), resEnWdata, vecs[i].wdata);
            end
            checkOutput($sformatf("v%0d other ready", i),   32'(resOtherReady), 32'd0);
            checkOutput($sformatf("v%0d stray mem", i),     32'(resStray),      32'd0);
            checkOutput($sformatf("v%0d cpu_rdata", i),     cpuRdata,           vecs[i].expCpuRdata);
            checkOutput($sformatf("v%0d dma_rdata", i),     dmaRdata,           vecs[i].expDmaRdata);
            checkOutput($sformatf("v%0d owner", i),         32'(owner),         32'(vecs[i].isDma));
            checkOutput($sformatf("v%0d ready pulse", i),   32'({cpuReady, dmaReady}), 32'd0);
            checkOutput($sformatf("v%0d busy after", i),    32'(busy),          32'd0);
        end

        // Reset asserted while an access is in ISSUE
        $display("[TB] reset mid-access");
        cpuWe = 1'b0; cpuAddr = 32'h80; cpuReq = 1'b1;
        @(negedge clk);
        checkOutput("midrst issue mem_en", 32'(memEn), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst mem_en",    32'(memEn),    32'd0);
        checkOutput("midrst mem_addr",  memAddr,       32'd0);
        checkOutput("midrst busy",      32'(busy),     32'd0);
        checkOutput("midrst owner",     32'(owner),    32'd0);
        checkOutput("midrst cpu_rdata", cpuRdata,      32'd0);
        checkOutput("midrst dma_rdata", dmaRdata,      32'd0);
        checkOutput("midrst cpu_ready", 32'(cpuReady), 32'd0);
        cpuReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("postrst idle busy c%0d", c), 32'({busy, memEn}), 32'd0);
        end

        // Simultaneous requests straight after reset: last served is DMA,
        // so both policies start with the CPU.
        $display("[TB] simultaneous requests");
        runDual(32'h1357_2468);
        checkOutput("dual1 first who",    32'(dualWho1),   32'd1);
        checkOutput("dual1 first cycle",  32'(dualCycle1), 32'd3);
        checkOutput("dual1 first owner",  32'(dualOwner1), 32'd0);
        checkOutput("dual1 second who",   32'(dualWho2),   32'd2);
        checkOutput("dual1 second cycle", 32'(dualCycle2), 32'd7);
        checkOutput("dual1 second owner", 32'(dualOwner2), 32'd1);
        checkOutput("dual1 cpu_rdata",    cpuRdata,        32'h1357_2468);
        checkOutput("dual1 dma_rdata",    dmaRdata,        32'h1357_2468);

        // CPU served last, then a tie
        applyStimulus(1'b0, 1'b0, 32'h44, 32'h0, 32'h0000_0777);
        checkOutput("cpu solo latency", 32'(resReadyCycle), 32'd3);
        runDual(32'h0000_0888);
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("dual2 first who",  32'(dualWho1), 32'd2);
        checkOutput("dual2 second who", 32'(dualWho2), 32'd1);
`else
        checkOutput("dual2 first who",  32'(dualWho1), 32'd1);
        checkOutput("dual2 second who", 32'(dualWho2), 32'd2);
`endif
        checkOutput("dual2 second cycle", 32'(dualCycle2), 32'd7);

        // Reset during WAIT of a DMA read, request kept high across reset
        $display("[TB] reset during DMA wait");
        cpuBefore = cpuRdata;
        memRdata = 32'h2468_ACE0;
        dmaWe = 1'b0; dmaAddr = 32'h500; dmaReq = 1'b1;
        @(negedge clk);
        checkOutput("abort issue mem_en", 32'(memEn), 32'd1);
        @(negedge clk);
        checkOutput("abort wait state", 32'({busy, memEn, dmaReady}), 32'b100);
        reset = 1'b0;
        #1;
        checkOutput("abort busy",      32'(busy),     32'd0);
        checkOutput("abort dma_ready", 32'(dmaReady), 32'd0);
        @(negedge clk);
        checkOutput("abort dma_rdata", dmaRdata, 32'd0);
        checkOutput("abort cpu_rdata", cpuRdata, 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 32'h2468_ACE0);
        checkOutput("replay latency",   32'(resReadyCycle), 32'd3);
        checkOutput("replay mem_en",    32'(resEnCount),    32'd1);
        checkOutput("replay mem_addr",  resEnAddr,          32'h500);
        checkOutput("replay dma_rdata", dmaRdata,           32'h2468_ACE0);
        if (cpuBefore == 32'h0) begin
            checkOutput("replay cpu_rdata", cpuRdata, 32'd0);
        end

        // MEM_LAT = 3 instance: CPU read
        $display("[TB] MEM_LAT=3 read");
        readyCycle = -1;
        enCount    = 0;
        cpuAddr2   = 32'h40;
        cpuReq2    = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (memEn2) begin
                enCount++;
                checkOutput("lat3 mem_en cycle", 32'(c), 32'd1);
                checkOutput("lat3 mem_addr",     memAddr2, 32'h40);
            end
            if (cpuReady2) begin
                readyCycle = c;
                break;
            end
        end
        cpuReq2 = 1'b0;
        checkOutput("lat3 ready latency", 32'(readyCycle), 32'd5);
        checkOutput("lat3 mem_en count",  32'(enCount),    32'd1);
        checkOutput("lat3 cpu_rdata",     cpuRdata2,       32'hA000_0003);
        checkOutput("lat3 dma_ready",     32'(dmaReady2),  32'd0);
        @(negedge clk);
        checkOutput("lat3 busy after", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
